sipo_frame_ctrl: RTL and testbench
==================================

// Module: sipo_frame_ctrl
// PURPOSE
//  Frames a serial bit stream into WIDTH-bit words on top of a SIPO shift register.
//  A start-of-frame strobe aligns the stream; the controller counts bits and, once a word is
//  complete, places it in a one-entry output holding register with a valid/ready handshake.
//  Overflow is reported when a word completes while the previous word is still unaccepted.
//  Sits between a serial link front-end and any parallel consumer.
// PARAMETERS
//  WIDTH      4   bits per word; legal range 2..32.
//  MSB_FIRST  1   1: the first serial bit lands in out_data[WIDTH-1]; 0: it lands in out_data[0].
// PORTS
//  clk        in   1      clock; all state updates on the rising edge.
//  rst        in   1      reset; asynchronous, active-high.
//  sin        in   1      serial data bit; sampled only when sin_vld=1.
//  sin_vld    in   1      bit strobe: sin is valid in this cycle.
//  sof        in   1      start of frame; meaningful only when sin_vld=1. Marks sin as word bit 0.
//  out_data   out  WIDTH  completed word; stable while out_valid=1.
//  out_valid  out  1      out_data holds an unconsumed word.
//  out_ready  in   1      consumer accepts the word on a cycle where out_valid && out_ready.
//  busy       out  1      1 while in SHIFT with a partial word (bit count != 0).
//  ovf        out  1      sticky overflow flag.
//  clr_ovf    in   1      synchronous clear of ovf.
// BEHAVIOUR
//  Reset values: FSM=IDLE, bit count=0, shift reg=0, out_data=0, out_valid=0, ovf=0, busy=0.
//  Reset takes effect mid-word: the partial word is lost and a held word is dropped.
//  FSM states:
//   IDLE : the controller ignores sin_vld unless sof=1. sin_vld&&sof -> shift in sin, cnt=1, go to SHIFT.
//   SHIFT: each sin_vld shifts in sin and increments cnt.
//          On the WIDTH-th bit, cnt wraps to 0 and the word completes. The FSM stays in SHIFT.
//          Streaming is continuous: the next bit starts the next word without needing sof.
//          sin_vld&&sof in SHIFT aborts the partial word (no flag). That bit becomes bit 0 (cnt=1).
//  Shift rule (MSB_FIRST=1): sr <= {sr[WIDTH-2:0], sin}. MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
//  Completion: at the edge that samples the last bit, out_data loads the next-state shift value,
//   which includes that bit.
//  Latency: out_valid rises in the cycle directly after the last bit's sampling edge.
//  Handshake:
//   - out_valid falls at the edge where out_valid&&out_ready, unless a new word completes at the same edge.
//   - On that simultaneous accept and completion, the new word loads and out_valid stays 1.
//   - Completion while out_valid=1 and out_ready=0: the new word is dropped, out_data is unchanged, ovf<=1.
//  ovf: set has priority over clr_ovf in the same cycle. Otherwise clr_ovf -> 0.
//  busy is a registered flag: (state==SHIFT && cnt!=0).
//  out_ready with out_valid=0 has no effect.
//  sin_vld=0 cycles freeze the count and the shift register in any state.
// STRUCTURE
//  Shared package sipo_pkg:
//   - FSM state constants: ST_IDLE=1'b0, ST_SHIFT=1'b1.
//   - CNT_W = $clog2(WIDTH+1) helper.
//  Sub-module sipo_shift_core:
//   - WIDTH-bit shift register with shift enable, a sync clear, and direction param MSB_FIRST.
//   - Outputs both its current and next value.
//   - The controller instantiates one.
//  Top holds: FSM, bit counter, output holding register, and the ovf flag.
// TESTING (WIDTH=4, MSB_FIRST=1 unless noted)
//  1. rst pulse mid-word after 2 bits -> all outputs 0 asynchronously. Bits following without sof are ignored.
//  2. sof with bits 1,0,1,1 on consecutive cycles, out_ready=1
//     -> out_data=4'b1011, out_valid=1 for exactly 1 cycle, one cycle after the 4th bit. busy=0 afterwards.
//  3. Continuous stream 1011 0110 with no second sof, out_ready=1 -> two words 4'hB then 4'h6. ovf=0.
//  4. out_ready=0, two words 4'hB and 4'h6 -> out_data stays 4'hB, ovf=1.
//     Then out_ready=1 -> handoff of 4'hB. clr_ovf -> ovf=0.
//  5. sof at bits 0,2 of a frame, then 4 bits 0011 -> the first partial word is aborted and only 4'h3 is produced.
//  6. MSB_FIRST=0, bits 1,0,0,0 -> out_data=4'b0001. Also: accept at the same edge a new word completes
//     -> out_valid stays 1 and ovf stays 0.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO framing controller.
package sipo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width able to hold 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit serial-in shift register exposing both its current and next value.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             sin,
  output logic [WIDTH-1:0] sr,
  output logic [WIDTH-1:0] sr_next
);

  logic [WIDTH-1:0] base;

  // A clear in the same cycle as a shift starts the new word from an empty register.
  always_comb begin
    base    = clr ? '0 : sr;
    sr_next = base;
    if (shift_en) begin
      if (MSB_FIRST) sr_next = {base[WIDTH-2:0], sin};
      else           sr_next = {sin, base[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= sr_next;
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frames a serial bit stream into WIDTH-bit words with a one-entry valid/ready output
// register and a sticky overflow flag.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             start, take_bit, complete, load, drop;
  logic             valid_next, ovf_next, busy_next;
  logic [WIDTH-1:0] sr, sr_next;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .shift_en(take_bit),
    .clr     (start),
    .sin     (sin),
    .sr      (sr),
    .sr_next (sr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // A sof always restarts a word as bit 0, so an aborted partial word can never complete.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    complete   = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    valid_next = out_valid;
    ovf_next   = ovf;
    start      = sin_vld && sof;
    take_bit   = sin_vld && (sof || (state == ST_SHIFT));

    if (start) begin
      state_next = ST_SHIFT;
      cnt_next   = CNT_W'(1);
    end else if (take_bit) begin
      if (cnt == CNT_W'(WIDTH - 1)) begin
        cnt_next = '0;
        complete = 1'b1;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end

    if (complete) begin
      if (out_valid && !out_ready) begin
        drop     = 1'b1;
        ovf_next = 1'b1;
      end else begin
        load       = 1'b1;
        valid_next = 1'b1;
      end
    end else if (out_valid && out_ready) begin
      valid_next = 1'b0;
    end

    if (!drop && clr_ovf) ovf_next = 1'b0;

    busy_next = (state_next == ST_SHIFT) && (cnt_next != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      out_valid <= valid_next;
      ovf       <= ovf_next;
      busy      <= busy_next;
      if (load) out_data <= sr_next;
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed and randomized checks of sipo_frame_ctrl (both bit orders) against a queue-based word model.
module tb_sipo_frame_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         sin_vld = 1'b0;
  logic         sof = 1'b0;
  logic         out_ready = 1'b0;
  logic         clr_ovf = 1'b0;
  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l, busy_m, busy_l, ovf_m, ovf_l;

  int checks = 0;
  int errors = 0;

  bit           framing;
  bit           bits[$];
  logic [W-1:0] exp_m, exp_l;
  bit           exp_valid, exp_ovf, exp_busy;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .sof(sof),
    .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
    .busy(busy_m), .ovf(ovf_m), .clr_ovf(clr_ovf)
  );

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .sof(sof),
    .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
    .busy(busy_l), .ovf(ovf_l), .clr_ovf(clr_ovf)
  );

  task automatic model_reset();
    framing   = 1'b0;
    bits.delete();
    exp_m     = '0;
    exp_l     = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_busy  = 1'b0;
  endtask

  // One clock of the word-level model, using the inputs seen at the edge.
  task automatic model_step();
    bit done    = 1'b0;
    bit set_ovf = 1'b0;
    if (sin_vld && sof) begin
      bits.delete();
      bits.push_back(sin);
      framing = 1'b1;
    end else if (sin_vld && framing) begin
      bits.push_back(sin);
      done = (bits.size() == W);
    end
    if (done) begin
      if (exp_valid && !out_ready) begin
        set_ovf = 1'b1;
      end else begin
        for (int i = 0; i < W; i++) begin
          exp_m[W-1-i] = bits[i];
          exp_l[i]     = bits[i];
        end
        exp_valid = 1'b1;
      end
      bits.delete();
    end else if (exp_valid && out_ready) begin
      exp_valid = 1'b0;
    end
    if (set_ovf)      exp_ovf = 1'b1;
    else if (clr_ovf) exp_ovf = 1'b0;
    exp_busy = framing && (bits.size() != 0);
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, ".data_msb"},  32'(data_m),  32'(exp_m));
    check_val({tag, ".data_lsb"},  32'(data_l),  32'(exp_l));
    check_val({tag, ".valid_msb"}, 32'(valid_m), 32'(exp_valid));
    check_val({tag, ".valid_lsb"}, 32'(valid_l), 32'(exp_valid));
    check_val({tag, ".busy_msb"},  32'(busy_m),  32'(exp_busy));
    check_val({tag, ".busy_lsb"},  32'(busy_l),  32'(exp_busy));
    check_val({tag, ".ovf_msb"},   32'(ovf_m),   32'(exp_ovf));
    check_val({tag, ".ovf_lsb"},   32'(ovf_l),   32'(exp_ovf));
  endtask

  // Drive one cycle of inputs, advance the model at the edge and compare just after it.
  task automatic apply_stimulus(input string tag, input logic v, input logic s, input logic f,
                                input logic r, input logic c);
    sin_vld   = v;
    sin       = s;
    sof       = f;
    out_ready = r;
    clr_ovf   = c;
    @(posedge clk);
    model_step();
    #1;
    check_output(tag);
  endtask

  task automatic send_word(input string tag, input logic [W-1:0] word, input logic first_sof,
                           input logic r);
    for (int i = W - 1; i >= 0; i--)
      apply_stimulus(tag, 1'b1, word[i], (i == W - 1) ? first_sof : 1'b0, r, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".data_msb"},  32'(data_m),  0);
    check_val({tag, ".data_lsb"},  32'(data_l),  0);
    check_val({tag, ".valid_msb"}, 32'(valid_m), 0);
    check_val({tag, ".busy_msb"},  32'(busy_m),  0);
    check_val({tag, ".ovf_msb"},   32'(ovf_m),   0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_all_zero(tag);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3 check_all_zero("por");
    #4 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-word, then bits without sof must be ignored
    apply_stimulus("t1.b0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus("t1.b1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("t1.busy_mid", 32'(busy_m), 1);
    pulse_reset("t1.rst");
    for (int i = 0; i < 5; i++)
      apply_stimulus("t1.nosof", 1'b1, 1'(i[0]), 1'b0, 1'b1, 1'b0);
    check_val("t1.ignored_valid", 32'(valid_m), 0);
    check_val("t1.ignored_busy",  32'(busy_m),  0);

    // Single framed word
    send_word("t2", 4'b1011, 1'b1, 1'b1);
    check_val("t2.data", 32'(data_m), 32'hB);
    check_val("t2.valid", 32'(valid_m), 1);
    check_val("t2.busy_after", 32'(busy_m), 0);
    apply_stimulus("t2.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("t2.valid_drop", 32'(valid_m), 0);

    // Continuous streaming without a second sof
    send_word("t3.w0", 4'b1011, 1'b1, 1'b1);
    check_val("t3.data0", 32'(data_m), 32'hB);
    send_word("t3.w1", 4'b0110, 1'b0, 1'b1);
    check_val("t3.data1", 32'(data_m), 32'h6);
    check_val("t3.ovf", 32'(ovf_m), 0);
    apply_stimulus("t3.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow while the consumer stalls, then handoff and clear
    send_word("t4.w0", 4'b1011, 1'b1, 1'b0);
    send_word("t4.w1", 4'b0110, 1'b0, 1'b0);
    check_val("t4.data_held", 32'(data_m), 32'hB);
    check_val("t4.ovf_set", 32'(ovf_m), 1);
    apply_stimulus("t4.accept", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("t4.valid_after_accept", 32'(valid_m), 0);
    apply_stimulus("t4.clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("t4.ovf_clr", 32'(ovf_m), 0);

    // sof mid-frame aborts the partial word
    apply_stimulus("t5.b0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus("t5.b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word("t5.w", 4'b0011, 1'b1, 1'b1);
    check_val("t5.data", 32'(data_m), 32'h3);
    check_val("t5.ovf", 32'(ovf_m), 0);
    apply_stimulus("t5.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // LSB-first order, then accept coinciding with completion
    send_word("t6.lsb", 4'b1000, 1'b1, 1'b1);
    check_val("t6.data_lsb", 32'(data_l), 32'h1);
    apply_stimulus("t6.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word("t6.wa", 4'b1100, 1'b1, 1'b0);
    apply_stimulus("t6.wb0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus("t6.wb1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus("t6.wb2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus("t6.wb3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("t6.simul_valid", 32'(valid_m), 1);
    check_val("t6.simul_ovf", 32'(ovf_m), 0);
    check_val("t6.simul_data", 32'(data_m), 32'h5);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      apply_stimulus("rnd",
                     1'($urandom_range(3) != 0),
                     1'($urandom_range(1)),
                     1'($urandom_range(9) == 0),
                     1'($urandom_range(1)),
                     1'($urandom_range(9) == 0));
      if ($urandom_range(99) == 0) pulse_reset("rnd.rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
